// File: rtl/led_pattern_arbiter_pkg.sv
// Shared constants for the status-LED arbiter: pattern codes, phase bit taps, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package led_pattern_arbiter_pkg;

    // Pattern codes carried on pat[2i+1:2i]
    localparam logic [1:0] PAT_OFF   = 2'b00;
    localparam logic [1:0] PAT_SOLID = 2'b01;
    localparam logic [1:0] PAT_SLOW  = 2'b10;
    localparam logic [1:0] PAT_FAST  = 2'b11;

    // Phase counter geometry and blink taps
    localparam int PHASE_W  = 9;
    localparam int SLOW_BIT = 8;   // 512-tick period
    localparam int FAST_BIT = 6;   // 128-tick period

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Millisecond prescaler with registered tick pulse and free-running 9-bit blink phase counter.
// Latency: first tick TICK_DIV cycles after reset release, then one pulse every TICK_DIV cycles.
// Backpressure: none; free-running.
//   clk, rst_n : clock and synchronous active-low reset
//   tick       : one-cycle pulse every TICK_DIV clocks
//   phase      : tick count modulo 512
module led_tick_gen
    import led_pattern_arbiter_pkg::*;
#(
    parameter int TICK_DIV = 125000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               tick,
    output logic [PHASE_W-1:0] phase
);

    localparam int               PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0]    LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc <= '0;
            tick  <= 1'b0;
            phase <= '0;
        end else begin
            if (presc == LAST) begin
                presc <= '0;
                tick  <= 1'b1;
            end else begin
                presc <= presc + PW'(1);
                tick  <= 1'b0;
            end
            // Phase advances on the registered pulse, so it lags tick by one cycle
            if (tick) begin
                phase <= phase + PHASE_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_arbiter.sv
// Fixed-priority arbiter (index 0 highest) with minimum hold time sharing one status LED.
// Latency: req -> grant 1 cycle; grant/pat -> led 1 further cycle.
// Backpressure: none; a requester simply waits at its req level until granted.
//   clk, rst_n : clock and synchronous active-low reset
//   req, pat   : per-source request level and 2-bit pattern code
//   grant      : registered one-hot owner (zero when idle)
//   led, tick  : registered LED drive and exported tick pulse
module led_pattern_arbiter
    import led_pattern_arbiter_pkg::*;
#(
    parameter int TICK_DIV   = 125000,
    parameter int NREQ       = 4,
    parameter int HOLD_TICKS = 250
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] pat,
    output logic [NREQ-1:0]   grant,
    output logic              led,
    output logic              tick
);

    localparam int            IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int            HW       = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);

    logic [PHASE_W-1:0] phase;

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick),
        .phase (phase)
    );

    arb_state_t    state;
    logic [IW-1:0] owner;
    logic [HW-1:0] hold;

    // Candidate selection: lowest set index among all / non-owner / higher-priority requesters
    logic          any_vld, oth_vld, hi_vld;
    logic [IW-1:0] any_idx, oth_idx, hi_idx;
    logic [1:0]    owner_pat;
    logic          pat_led;

    always_comb begin
        any_vld = 1'b0;
        oth_vld = 1'b0;
        hi_vld  = 1'b0;
        any_idx = '0;
        oth_idx = '0;
        hi_idx  = '0;
        // Scan downward so the last hit is the lowest index
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                any_vld = 1'b1;
                any_idx = IW'(i);
                if (i != int'(owner)) begin
                    oth_vld = 1'b1;
                    oth_idx = IW'(i);
                end
                if (i < int'(owner)) begin
                    hi_vld = 1'b1;
                    hi_idx = IW'(i);
                end
            end
        end
    end

    always_comb begin
        owner_pat = pat[{owner, 1'b0} +: 2];
        pat_led   = 1'b0;
        case (owner_pat)
            PAT_OFF:   pat_led = 1'b0;
            PAT_SOLID: pat_led = 1'b1;
            PAT_SLOW:  pat_led = phase[SLOW_BIT];
            PAT_FAST:  pat_led = phase[FAST_BIT];
            default:   pat_led = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            owner <= '0;
            hold  <= '0;
            grant <= '0;
            led   <= 1'b0;
        end else begin
            // LED follows the grant already registered, hence the extra cycle
            led <= (state == ST_OWN) ? pat_led : 1'b0;

            case (state)
                ST_IDLE: begin
                    if (any_vld) begin
                        state <= ST_OWN;
                        owner <= any_idx;
                        grant <= NREQ'(1) << any_idx;
                        hold  <= '0;
                    end
                end
                ST_OWN: begin
                    // Release wins over preemption when both happen together
                    if (!req[owner]) begin
                        hold <= '0;
                        if (oth_vld) begin
                            owner <= oth_idx;
                            grant <= NREQ'(1) << oth_idx;
                        end else begin
                            state <= ST_IDLE;
                            owner <= '0;
                            grant <= '0;
                        end
                    end else if (hi_vld && hold == HOLD_MAX) begin
                        owner <= hi_idx;
                        grant <= NREQ'(1) << hi_idx;
                        hold  <= '0;
                    end else if (tick && hold != HOLD_MAX) begin
                        hold <= hold + HW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_arbiter.sv
module tb_led_pattern_arbiter;

    localparam int TD = 4;
    localparam int NR = 4;
    localparam int HT = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req = '0;
    logic [7:0]    pat = '0;
    logic [NR-1:0] grant;
    logic          led;
    logic          tick;

    int checks   = 0;
    int failures = 0;

    led_pattern_arbiter #(
        .TICK_DIV   (TD),
        .NREQ       (NR),
        .HOLD_TICKS (HT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .pat   (pat),
        .grant (grant),
        .led   (led),
        .tick  (tick)
    );

    always #5 clk = ~clk;

    // Reference model: integer owner (-1 idle), tick count since reset release,
    // tick-count phase, hold measured in ticks.
    int m_owner = -1;
    int m_hold  = 0;
    int m_ncyc  = 0;
    int m_phase = 0;
    bit m_tick  = 1'b0;
    bit m_led   = 1'b0;

    function automatic int lowest(input logic [NR-1:0] m);
        for (int i = 0; i < NR; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic bit pattern_level(input int code, input int ph);
        case (code)
            0: return 1'b0;
            1: return 1'b1;
            2: return bit'((ph / 256) % 2);
            default: return bit'((ph / 64) % 2);
        endcase
    endfunction

    task automatic model_edge();
        int o_new, h_new, lo;
        bit l_new;
        if (!rst_n) begin
            m_owner = -1; m_hold = 0; m_ncyc = 0; m_phase = 0; m_tick = 0; m_led = 0;
            return;
        end
        l_new = (m_owner < 0) ? 1'b0 : pattern_level(int'((pat >> (2 * m_owner)) & 8'h3), m_phase);
        o_new = m_owner;
        h_new = m_hold;
        lo    = lowest(req);
        if (m_owner < 0) begin
            o_new = lo;
            h_new = 0;
        end else if (!req[m_owner]) begin
            o_new = lowest(req & ~(NR'(1) << m_owner));
            h_new = 0;
        end else if (lo < m_owner && m_hold == HT) begin
            o_new = lo;
            h_new = 0;
        end else if (m_tick) begin
            h_new = (m_hold + 1 > HT) ? HT : m_hold + 1;
        end
        m_phase = (m_phase + int'(m_tick)) % 512;
        m_ncyc++;
        m_tick  = (m_ncyc % TD) == 0;
        m_owner = o_new;
        m_hold  = h_new;
        m_led   = l_new;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance model at the edge, sample DUT 1 time unit later
    task automatic step();
        logic [NR-1:0] g_exp;
        @(posedge clk);
        model_edge();
        #1;
        g_exp = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
        chk("grant", 32'(grant), 32'(g_exp));
        chk("led", 32'(led), 32'(m_led));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("onehot", 32'($countones(grant) <= 1), 32'(1));
    endtask

    initial begin
        int n;
        // Reset, then idle with tick cadence
        step(); step();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("idle_tick_cadence", 32'(tick), 32'((i % 4) == 0));
            chk("idle_grant", 32'(grant), 32'h0);
        end

        // Single solid requester: grant then led one cycle later
        req = 4'b0100; pat = 8'b0001_0000;
        step(); chk("s2_grant", 32'(grant), 32'h4); chk("s2_led_lag", 32'(led), 32'h0);
        step(); chk("s2_led", 32'(led), 32'h1);
        req = 4'b0000;
        step(); chk("s2_drop_grant", 32'(grant), 32'h0); chk("s2_drop_led_lag", 32'(led), 32'h1);
        step(); chk("s2_drop_led", 32'(led), 32'h0);

        // Owner 2 slow blink, req[0] rises after a tick: preempt only at full hold
        req = 4'b0100; pat = 8'b0010_0000;
        step();
        for (int i = 0; i < 4; i++) step();
        req = 4'b0101;
        step(); chk("s3_no_early_preempt", 32'(grant), 32'h4);
        n = 0;
        while (grant != 4'b0001 && n < 40) begin step(); n++; end
        chk("s3_preempted", 32'(grant), 32'h1);

        // Owner 1, lower-priority req[3] never preempts; release hands over to 3
        req = 4'b0010;
        step(); chk("s4_owner1", 32'(grant), 32'h2);
        req = 4'b1010;
        for (int i = 0; i < 80; i++) begin
            step();
            chk("s4_no_low_preempt", 32'(grant), 32'h2);
        end
        req = 4'b1000;
        step(); chk("s4_release_to_3", 32'(grant), 32'h8);

        // Owner 0 fast blink, then slow blink
        req = 4'b0001; pat = 8'b0000_0011;
        for (int i = 0; i < 700; i++) step();
        pat = 8'b0000_0010;
        for (int i = 0; i < 1200; i++) step();

        // Reset during OWN with led on
        pat = 8'b0000_0001;
        step(); step();
        chk("s6_led_on", 32'(led), 32'h1);
        rst_n = 1'b0;
        step(); chk("s6_rst_grant", 32'(grant), 32'h0); chk("s6_rst_led", 32'(led), 32'h0);
        rst_n = 1'b1;
        step(); chk("s6_rearb", 32'(grant), 32'h1);

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(7, 0) == 0) req = NR'($urandom);
            if ($urandom_range(15, 0) == 0) pat = 8'($urandom);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_arbiter.md
Name: led_pattern_arbiter

Overview:
Shares the single board status LED between up to NREQ status sources (heartbeat, hash activity, error, and so on). Each source requests the LED together with a 2-bit pattern code. A fixed-priority arbiter with a minimum-ownership hold time decides which source drives the LED. The block also contains the shared millisecond prescaler and pattern phase counter, and exports the tick so other status logic can use it.

Parameters:
TICK_DIV, 125000, clk cycles per tick (1 ms at 125 MHz); must be >= 2.
NREQ, 4, number of requesters; index 0 has the highest priority.
HOLD_TICKS, 250, minimum ticks an owner keeps the LED before a higher-priority source may preempt it; must be >= 1.

Ports:
clk  in  1  system clock; all logic on posedge.
rst_n  in  1  synchronous active-low reset.
req  in  NREQ  per-source request level.
pat  in  2*NREQ  pattern for source i at pat[2i+1:2i]: 00 off, 01 solid, 10 slow blink, 11 fast blink.
grant  out  NREQ  registered one-hot owner; all-zero when idle.
led  out  1  registered LED drive.
tick  out  1  one-cycle pulse every TICK_DIV clocks.

Behaviour:
- Reset (rst_n=0 at a posedge): prescaler=0, phase=0, hold=0, state=IDLE, grant=0, led=0, tick=0. Reset takes precedence over every other event, including during OWN.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - tick is registered and is 1 in the cycle after the prescaler reaches TICK_DIV-1.
  - The first tick appears TICK_DIV cycles after reset release.
- Phase:
  - 9-bit free-running counter, incremented on each tick, wraps 511->0.
  - Slow blink = phase[8] (512-tick period, 50% duty).
  - Fast blink = phase[6] (128-tick period).
- State machine, IDLE / OWN:
  - IDLE: if any req bit is set, at the next posedge go to OWN, grant the lowest set index, and clear hold. If no req bit is set, stay in IDLE with grant=0.
  - OWN, owner o:
    - hold increments on each tick and saturates at HOLD_TICKS.
    - If req[o]=0: at the next posedge grant the lowest set index among the other requesters and clear hold. If none is set, go to IDLE.
    - If some req[j] is set with j<o and hold==HOLD_TICKS: preempt. Grant the lowest such j and clear hold.
    - Lower-priority requests never preempt.
    - A release and a higher-priority request in the same cycle resolve as a release (the hold check does not apply).
- Latency: req rise to grant is 1 cycle; grant/pattern to led is 1 more cycle.
- LED:
  - led is registered.
  - It is 0 when grant=0. Otherwise it follows the owner's current pat: 00 gives 0, 01 gives 1, 10 gives phase[8], 11 gives phase[6].
  - A pattern change by the owner is visible on led 1 cycle later and does not reset hold.
- Width rules: the prescaler width is $clog2(TICK_DIV); the hold width is $clog2(HOLD_TICKS+1); all counters are unsigned.
- Invariant: grant is always one-hot or zero.

Decomposition:
- Shared package: the pattern code constants (PAT_OFF=2'b00, PAT_SOLID=2'b01, PAT_SLOW=2'b10, PAT_FAST=2'b11) and the phase bit indices (SLOW_BIT=8, FAST_BIT=6).
- One natural sub-module: led_tick_gen (prescaler, tick, phase counter).
- The arbiter FSM and the LED mux stay in the top module.

Test Plan:
Use TICK_DIV=4, HOLD_TICKS=3, NREQ=4 for all scenarios.
- Reset then idle, req=0: grant=0 and led=0 forever; tick pulses every 4 cycles, first pulse 4 cycles after rst_n rises.
- req=4'b0100, pat2=01 at cycle c: grant=4'b0100 at c+1 and led=1 at c+2. Drop req at d: grant=0 at d+1, led=0 at d+2.
- Owner 2 (pat2=10) holds; req[0] rises after 1 tick: grant stays 0100 until hold reaches 3, then becomes 0001 on the next posedge.
- Owner 1 holds; req[3] rises: no preemption for 20 ticks. Drop req[1]: grant=1000 next cycle, with hold restarted from 0.
- Owner 0 with pat0=11: led toggles every 64 ticks (256 clocks) in step with phase[6]. Switching pat0 to 10 makes led follow phase[8] within 1 cycle.
- Assert rst_n=0 for one cycle while in OWN with led=1: grant=0 and led=0 at that posedge; re-arbitration happens 1 cycle after release.
